mux_rr_stream: RTL and testbench



---
 rtl/mux_rr_stream.sv | 104 ++++++++++
 tb/tb_mux_rr_stream.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mux_rr_stream.sv
// N_CH:1 valid/ready stream selector with manual or round-robin channel choice
// and a single registered output slot that refills as it drains.
module mux_rr_stream #(
  parameter  int NB_DATA = 4,
  parameter  int N_CH    = 4,
  localparam int NB_SEL  = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH*NB_DATA-1:0] e_data,
  input  logic [N_CH-1:0]         e_valid,
  output logic [N_CH-1:0]         s_ready,
  input  logic                    e_mode,
  input  logic [NB_SEL-1:0]       e_muxsel,
  output logic [NB_DATA-1:0]      s_data,
  output logic                    s_valid,
  input  logic                    e_ready,
  output logic [NB_SEL-1:0]       s_grant,
  output logic                    s_sel_err
);

  localparam logic [NB_SEL:0]   NCH_L  = (NB_SEL+1)'(N_CH);
  localparam logic [NB_SEL-1:0] LAST_L = NB_SEL'(N_CH-1);

  logic [NB_DATA-1:0] s_data_q, s_data_d;
  logic               s_valid_q, s_valid_d;
  logic [NB_SEL-1:0]  s_grant_q, s_grant_d;
  logic               s_sel_err_q, s_sel_err_d;
  logic [NB_SEL-1:0]  rr_last_q, rr_last_d;

  logic               load_en, in_range, rr_found, usable, cand_vld, xfer;
  logic [NB_SEL-1:0]  rr_cand, cand;
  logic [NB_DATA-1:0] cand_data;
  int                 idx;

  always_comb begin
    load_en  = !rst && (!s_valid_q || e_ready);
    in_range = {1'b0, e_muxsel} < NCH_L;

    // Search starts one past the last round-robin winner and wraps.
    rr_found = 1'b0;
    rr_cand  = '0;
    idx      = 0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(rr_last_q) + k) % N_CH;
      if (!rr_found && e_valid[idx]) begin
        rr_found = 1'b1;
        rr_cand  = NB_SEL'(idx);
      end
    end

    cand   = e_mode ? rr_cand  : e_muxsel;
    usable = e_mode ? rr_found : in_range;

    // Manual-mode ready is offered regardless of the channel's own valid.
    cand_data = '0;
    cand_vld  = 1'b0;
    s_ready   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cand == NB_SEL'(i)) begin
        cand_data  = e_data[i*NB_DATA +: NB_DATA];
        cand_vld   = e_valid[i];
        s_ready[i] = usable && load_en;
      end
    end
    xfer = usable && load_en && cand_vld;

    s_data_d    = s_data_q;
    s_valid_d   = s_valid_q;
    s_grant_d   = s_grant_q;
    rr_last_d   = rr_last_q;
    s_sel_err_d = !e_mode && !in_range;
    if (load_en) begin
      s_valid_d = xfer;
      if (xfer) begin
        s_data_d  = cand_data;
        s_grant_d = cand;
        if (e_mode) rr_last_d = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_data_q    <= '0;
      s_valid_q   <= 1'b0;
      s_grant_q   <= '0;
      s_sel_err_q <= 1'b0;
      rr_last_q   <= LAST_L;
    end else begin
      s_data_q    <= s_data_d;
      s_valid_q   <= s_valid_d;
      s_grant_q   <= s_grant_d;
      s_sel_err_q <= s_sel_err_d;
      rr_last_q   <= rr_last_d;
    end
  end

  assign s_data    = s_data_q;
  assign s_valid   = s_valid_q;
  assign s_grant   = s_grant_q;
  assign s_sel_err = s_sel_err_q;

endmodule

// File: tb/tb_mux_rr_stream.sv
// Directed bench for mux_rr_stream: a vector table on a 4-channel instance and
// a hand sequence on a 3-channel instance for the out-of-range select.
module tb_mux_rr_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 4-channel instance
  logic        rst, mode, rdy, s_valid, s_err;
  logic [1:0]  sel, s_grant;
  logic [3:0]  ev, s_ready, s_data;
  logic [15:0] data;

  mux_rr_stream #(.NB_DATA(4), .N_CH(4)) dut (
    .clk(clk), .rst(rst), .e_data(data), .e_valid(ev), .s_ready(s_ready),
    .e_mode(mode), .e_muxsel(sel), .s_data(s_data), .s_valid(s_valid),
    .e_ready(rdy), .s_grant(s_grant), .s_sel_err(s_err)
  );

  // 3-channel instance
  logic        rst3, mode3, rdy3, s_valid3, s_err3;
  logic [1:0]  sel3, s_grant3;
  logic [2:0]  ev3, s_ready3;
  logic [3:0]  s_data3;
  logic [11:0] data3;

  mux_rr_stream #(.NB_DATA(4), .N_CH(3)) dut3 (
    .clk(clk), .rst(rst3), .e_data(data3), .e_valid(ev3), .s_ready(s_ready3),
    .e_mode(mode3), .e_muxsel(sel3), .s_data(s_data3), .s_valid(s_valid3),
    .e_ready(rdy3), .s_grant(s_grant3), .s_sel_err(s_err3)
  );

  typedef struct {
    logic       rst, mode;
    logic [1:0] sel;
    logic [3:0] ev;
    logic       rdy;
    logic [3:0] x_rdy;
    logic       x_v;
    logic [3:0] x_d;
    logic [1:0] x_g;
    logic       x_e;
  } vec_t;

  localparam int NV = 23;
  vec_t vt [NV];

  function automatic vec_t mk(logic r, logic m, logic [1:0] s, logic [3:0] e, logic rd,
                              logic [3:0] xr, logic xv, logic [3:0] xd, logic [1:0] xg,
                              logic xe);
    vec_t v;
    v.rst = r; v.mode = m; v.sel = s; v.ev = e; v.rdy = rd;
    v.x_rdy = xr; v.x_v = xv; v.x_d = xd; v.x_g = xg; v.x_e = xe;
    return v;
  endfunction

  task automatic chk(string nm, int idx, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic step3(int n, logic r, logic m, logic [1:0] s, logic [2:0] e,
                       logic [2:0] xr, logic xv, logic [3:0] xd, logic [1:0] xg, logic xe);
    @(negedge clk);
    rst3 = r; mode3 = m; sel3 = s; ev3 = e; rdy3 = 1'b1;
    #1;
    chk("ready3", n, 16'(s_ready3), 16'(xr));
    @(posedge clk); #1;
    chk("valid3", n, 16'(s_valid3), 16'(xv));
    chk("data3",  n, 16'(s_data3),  16'(xd));
    chk("grant3", n, 16'(s_grant3), 16'(xg));
    chk("selerr3", n, 16'(s_err3),  16'(xe));
  endtask

  initial begin
    // ch0=5 ch1=7 ch2=A ch3=C
    data = 16'hCA75;
    rst = 1'b1; mode = 1'b0; sel = 2'd0; ev = 4'b0; rdy = 1'b1;
    data3 = 12'h975;
    rst3 = 1'b1; mode3 = 1'b0; sel3 = 2'd0; ev3 = 3'b0; rdy3 = 1'b1;

    //          rst mode sel ev       rdy  x_rdy    xv  xd     xg  xe
    vt[0]  = mk(1, 0, 2, 4'b0100, 1, 4'b0000, 0, 4'h0, 0, 0);
    vt[1]  = mk(0, 0, 2, 4'b0100, 1, 4'b0100, 1, 4'hA, 2, 0);
    vt[2]  = mk(0, 0, 2, 4'b0000, 1, 4'b0100, 0, 4'hA, 2, 0);
    vt[3]  = mk(0, 0, 1, 4'b0100, 1, 4'b0010, 0, 4'hA, 2, 0);
    vt[4]  = mk(0, 1, 0, 4'b1111, 1, 4'b0001, 1, 4'h5, 0, 0);
    vt[5]  = mk(0, 1, 0, 4'b1111, 1, 4'b0010, 1, 4'h7, 1, 0);
    vt[6]  = mk(0, 1, 0, 4'b1111, 1, 4'b0100, 1, 4'hA, 2, 0);
    vt[7]  = mk(0, 1, 0, 4'b1111, 1, 4'b1000, 1, 4'hC, 3, 0);
    vt[8]  = mk(0, 1, 0, 4'b1111, 1, 4'b0001, 1, 4'h5, 0, 0);
    vt[9]  = mk(0, 1, 0, 4'b1010, 1, 4'b0010, 1, 4'h7, 1, 0);
    vt[10] = mk(0, 1, 0, 4'b1010, 1, 4'b1000, 1, 4'hC, 3, 0);
    vt[11] = mk(0, 1, 0, 4'b1010, 1, 4'b0010, 1, 4'h7, 1, 0);
    vt[12] = mk(0, 1, 0, 4'b1010, 1, 4'b1000, 1, 4'hC, 3, 0);
    vt[13] = mk(0, 1, 0, 4'b0001, 1, 4'b0001, 1, 4'h5, 0, 0);
    vt[14] = mk(0, 1, 0, 4'b1111, 0, 4'b0000, 1, 4'h5, 0, 0);
    vt[15] = mk(0, 1, 3, 4'b1111, 0, 4'b0000, 1, 4'h5, 0, 0);
    vt[16] = mk(0, 1, 1, 4'b1111, 0, 4'b0000, 1, 4'h5, 0, 0);
    vt[17] = mk(0, 1, 0, 4'b1111, 1, 4'b0010, 1, 4'h7, 1, 0);
    vt[18] = mk(1, 1, 0, 4'b1111, 1, 4'b0000, 0, 4'h0, 0, 0);
    vt[19] = mk(0, 1, 0, 4'b1111, 1, 4'b0001, 1, 4'h5, 0, 0);
    vt[20] = mk(0, 0, 3, 4'b1111, 1, 4'b1000, 1, 4'hC, 3, 0);
    vt[21] = mk(0, 1, 0, 4'b1111, 1, 4'b0010, 1, 4'h7, 1, 0);
    vt[22] = mk(0, 1, 0, 4'b0000, 1, 4'b0000, 0, 4'h7, 1, 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = vt[i].rst; mode = vt[i].mode; sel = vt[i].sel; ev = vt[i].ev; rdy = vt[i].rdy;
      #1;
      chk("ready", i, 16'(s_ready), 16'(vt[i].x_rdy));
      @(posedge clk); #1;
      chk("valid",  i, 16'(s_valid), 16'(vt[i].x_v));
      chk("data",   i, 16'(s_data),  16'(vt[i].x_d));
      chk("grant",  i, 16'(s_grant), 16'(vt[i].x_g));
      chk("selerr", i, 16'(s_err),   16'(vt[i].x_e));
    end

    // 3 channels: out-of-range select, then round-robin wrap over a non-power-of-2 count
    //    n  rst mode sel ev      x_rdy   xv  xd    xg  xe
    step3(0, 1, 0, 1, 3'b010, 3'b000, 0, 4'h0, 0, 0);
    step3(1, 0, 0, 1, 3'b010, 3'b010, 1, 4'h7, 1, 0);
    step3(2, 0, 0, 3, 3'b010, 3'b000, 0, 4'h7, 1, 1);
    step3(3, 0, 0, 1, 3'b010, 3'b010, 1, 4'h7, 1, 0);
    step3(4, 0, 1, 3, 3'b111, 3'b001, 1, 4'h5, 0, 0);
    step3(5, 0, 1, 3, 3'b111, 3'b010, 1, 4'h7, 1, 0);
    step3(6, 0, 1, 3, 3'b111, 3'b100, 1, 4'h9, 2, 0);
    step3(7, 0, 1, 3, 3'b111, 3'b001, 1, 4'h5, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
